// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer.
//   seq_state_t       : 2-bit FSM state encoding (BOOT, RUN, DRAIN, FLUSH)
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   PC_INCR           : sequential fetch increment
//   REDIRECT_CNT_W    : width of the saturating redirect counter
//   align_word()      : clears the byte-offset bits of an address
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } seq_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam int          REDIRECT_CNT_W   = 16;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus bundle between the PC sequencer and its environment (hazard unit,
// instruction memory, branch resolution, pipeline flush targets).
//   master : the sequencer (drives Pc, fetch/flush controls, status)
//   slave  : the environment (drives stall, memory ready, branch info)
interface pc_sequencer_if;
    logic        Stall;
    logic        Imem_ready;
    logic        Exmem_branch;
    logic [31:0] Exmem_pc_4;
    logic [31:0] Final_target;
    logic [31:0] Pc;
    logic        Fetch_req;
    logic        Ifid_write;
    logic        Drop_fetch;
    logic        Flush_ifid;
    logic        Flush_idex;
    logic        Flush_exmem;
    logic [15:0] Redirect_cnt;
    logic        Misalign_err;

    modport master (
        input  Stall, Imem_ready, Exmem_branch, Exmem_pc_4, Final_target,
        output Pc, Fetch_req, Ifid_write, Drop_fetch,
               Flush_ifid, Flush_idex, Flush_exmem, Redirect_cnt, Misalign_err
    );

    modport slave (
        output Stall, Imem_ready, Exmem_branch, Exmem_pc_4, Final_target,
        input  Pc, Fetch_req, Ifid_write, Drop_fetch,
               Flush_ifid, Flush_idex, Flush_exmem, Redirect_cnt, Misalign_err
    );
endinterface

// File: rtl/pc_sequencer_redirect_counter.sv
// Saturating up-counter with enable.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   en    : increment request for this cycle
//   count : current value; sticks at all-ones
module redirect_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (en && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: generates the fetch address, handles memory wait
// states and load-use stalls, and redirects fetch on a mispredicted
// branch/jump resolved in EX/MEM.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pc_sequencer_if.master (inputs from hazard unit, imem and
//                branch resolution; outputs Pc, fetch/flush controls,
//                Redirect_cnt, Misalign_err)
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);
    seq_state_t  state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] pend_reg, pend_next;
    logic        mis_reg, mis_next;

    logic        redirect_req;
    logic        redirect_accept;
    logic [31:0] target_aligned;
    logic        fetch_req;
    logic        ifid_write;
    logic        drop_fetch;
    logic        flush_all;

    // A redirect is only a request here; whether it is honoured depends on state.
    assign redirect_req   = bus.Exmem_branch && (bus.Final_target != bus.Exmem_pc_4);
    assign target_aligned = align_word(bus.Final_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_BOOT;
            pc_reg    <= RESET_PC;
            pend_reg  <= '0;
            mis_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            pend_reg  <= pend_next;
            mis_reg   <= mis_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pend_next       = pend_reg;
        fetch_req       = 1'b0;
        ifid_write      = 1'b0;
        drop_fetch      = 1'b0;
        flush_all       = 1'b0;
        redirect_accept = 1'b0;

        case (state_reg)
            ST_BOOT: begin
                state_next = ST_RUN;
            end

            ST_RUN: begin
                fetch_req = 1'b1;
                if (redirect_req) begin
                    // Redirect beats stall: the wrong-path fetch is killed.
                    redirect_accept = 1'b1;
                    flush_all       = 1'b1;
                    if (bus.Imem_ready) begin
                        drop_fetch = 1'b1;
                        pc_next    = target_aligned;
                        state_next = ST_FLUSH;
                    end else begin
                        // Memory still owns the old request; wait for it to return.
                        pend_next  = target_aligned;
                        state_next = ST_DRAIN;
                    end
                end else if (bus.Imem_ready && !bus.Stall) begin
                    ifid_write = 1'b1;
                    pc_next    = pc_reg + PC_INCR;
                end
            end

            ST_DRAIN: begin
                fetch_req = 1'b1;
                if (redirect_req) begin
                    redirect_accept = 1'b1;
                    flush_all       = 1'b1;
                    pend_next       = target_aligned;
                end
                if (bus.Imem_ready) begin
                    // The returning instruction belongs to the abandoned path.
                    drop_fetch = 1'b1;
                    pc_next    = redirect_req ? target_aligned : pend_reg;
                    state_next = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                // One settling cycle: fetch as normal, redirects are ignored.
                fetch_req  = 1'b1;
                state_next = ST_RUN;
                if (bus.Imem_ready && !bus.Stall) begin
                    ifid_write = 1'b1;
                    pc_next    = pc_reg + PC_INCR;
                end
            end

            default: begin
                state_next = ST_BOOT;
            end
        endcase

        mis_next = mis_reg | (redirect_accept && (bus.Final_target[1:0] != 2'b00));
    end

    redirect_counter #(
        .WIDTH (REDIRECT_CNT_W)
    ) u_redirect_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (redirect_accept),
        .count (bus.Redirect_cnt)
    );

    assign bus.Pc           = pc_reg;
    assign bus.Fetch_req    = fetch_req;
    assign bus.Ifid_write   = ifid_write;
    assign bus.Drop_fetch   = drop_fetch;
    assign bus.Flush_ifid   = flush_all;
    assign bus.Flush_idex   = flush_all;
    assign bus.Flush_exmem  = flush_all;
    assign bus.Misalign_err = mis_reg;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized traffic, all compared against a behavioural model that tracks
// the expected fetch address, pending redirect and counters.
module tb_pc_sequencer;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk;
    logic rst_n;
    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;
    int n_cycle;
    bit quiet;

    // Behavioural model state
    bit          m_boot;     // first cycle after reset, no fetch yet
    bit          m_drain;    // redirect accepted, old fetch still outstanding
    bit          m_settle;   // cycle after a redirect took effect
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    logic [15:0] m_cnt;
    bit          m_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", tag, n_cycle, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot   = 1'b1;
        m_drain  = 1'b0;
        m_settle = 1'b0;
        m_pc     = RST_PC;
        m_pend   = '0;
        m_cnt    = '0;
        m_mis    = 1'b0;
    endtask

    // Called at a falling edge: drive, check, advance model, wait one cycle.
    task automatic step(input logic st, input logic rd, input logic br,
                        input logic [31:0] p4, input logic [31:0] tg);
        logic e_fetch, e_redir, e_drop, e_ifid;
        bus.Stall        = st;
        bus.Imem_ready   = rd;
        bus.Exmem_branch = br;
        bus.Exmem_pc_4   = p4;
        bus.Final_target = tg;
        #1;
        e_fetch = !m_boot;
        e_redir = !m_boot && !m_settle && br && (tg != p4);
        e_drop  = e_fetch && rd && (e_redir || m_drain);
        e_ifid  = e_fetch && rd && !st && !e_redir && !m_drain;

        if (!quiet)
            $display("cyc %0d st=%b rd=%b br=%b p4=%08h tg=%08h | pc=%08h req=%b ifid=%b drop=%b fl=%b cnt=%0d mis=%b",
                     n_cycle, st, rd, br, p4, tg, bus.Pc, bus.Fetch_req, bus.Ifid_write,
                     bus.Drop_fetch, bus.Flush_ifid, bus.Redirect_cnt, bus.Misalign_err);

        check("pc",          bus.Pc,           m_pc);
        check("fetch_req",   bus.Fetch_req,    e_fetch);
        check("ifid_write",  bus.Ifid_write,   e_ifid);
        check("drop_fetch",  bus.Drop_fetch,   e_drop);
        check("flush_ifid",  bus.Flush_ifid,   e_redir);
        check("flush_idex",  bus.Flush_idex,   e_redir);
        check("flush_exmem", bus.Flush_exmem,  e_redir);
        check("redir_cnt",   bus.Redirect_cnt, m_cnt);
        check("misalign",    bus.Misalign_err, m_mis);

        if (m_boot) begin
            m_boot = 1'b0;
        end else if (e_redir) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (tg[1:0] != 2'b00) m_mis = 1'b1;
            if (rd) begin
                m_pc     = tg & ~32'h3;
                m_drain  = 1'b0;
                m_settle = 1'b1;
            end else begin
                m_pend  = tg & ~32'h3;
                m_drain = 1'b1;
            end
        end else if (m_drain) begin
            if (rd) begin
                m_pc     = m_pend;
                m_drain  = 1'b0;
                m_settle = 1'b1;
            end
        end else begin
            if (rd && !st) m_pc = m_pc + 32'd4;
            m_settle = 1'b0;
        end

        @(negedge clk);
        n_cycle++;
    endtask

    // Assert reset at a falling edge, check outputs while held, release at a falling edge.
    task automatic apply_reset();
        rst_n            = 1'b0;
        bus.Stall        = 1'b0;
        bus.Imem_ready   = 1'b1;
        bus.Exmem_branch = 1'b1;
        bus.Exmem_pc_4   = 32'h0000_0010;
        bus.Final_target = 32'h0000_0777;
        #1;
        check("rst_pc",        bus.Pc,           RST_PC);
        check("rst_fetch_req", bus.Fetch_req,    1'b0);
        check("rst_ifid",      bus.Ifid_write,   1'b0);
        check("rst_drop",      bus.Drop_fetch,   1'b0);
        check("rst_flush",     {bus.Flush_ifid, bus.Flush_idex, bus.Flush_exmem}, 3'b000);
        check("rst_cnt",       bus.Redirect_cnt, 16'h0);
        check("rst_mis",       bus.Misalign_err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_cycle  = 0;
        quiet    = 1'b0;
        rst_n    = 1'b1;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Sequential fetch after reset: 0, 0, 4, 8
        check("boot_pc0", bus.Pc, 32'h0);
        step(0, 1, 0, 32'h0, 32'h0);
        check("boot_pc1", bus.Pc, 32'h0);
        step(0, 1, 0, 32'h0, 32'h0);
        check("boot_pc2", bus.Pc, 32'h4);
        step(0, 1, 0, 32'h0, 32'h0);
        check("boot_pc3", bus.Pc, 32'h8);
        step(0, 1, 0, 32'h0, 32'h0);

        // Redirect in RUN with memory ready
        step(0, 1, 1, 32'h20, 32'h100);
        check("redir_pc", bus.Pc, 32'h100);
        check("redir_cnt1", bus.Redirect_cnt, 16'd1);
        step(0, 1, 0, 32'h0, 32'h0);

        // Redirect while memory is busy: drain, then load target
        step(0, 0, 1, 32'h20, 32'h200);
        step(0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0);
        check("drain_hold_pc", bus.Pc, 32'h104);
        step(0, 1, 0, 32'h0, 32'h0);
        check("drain_pc", bus.Pc, 32'h200);
        step(0, 1, 0, 32'h0, 32'h0);

        // Redirect beats stall; redirect in the settle cycle is ignored
        step(1, 1, 1, 32'h30, 32'h40);
        check("stall_redir_pc", bus.Pc, 32'h40);
        step(0, 1, 1, 32'h50, 32'h300);
        check("settle_ignore_pc", bus.Pc, 32'h44);
        check("settle_ignore_cnt", bus.Redirect_cnt, 16'd3);

        // Misaligned target
        step(0, 1, 1, 32'h10, 32'h103);
        check("misalign_pc", bus.Pc, 32'h100);
        check("misalign_flag", bus.Misalign_err, 1'b1);
        step(0, 1, 0, 32'h0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic st, rd, br;
            logic [31:0] p4, tg;
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 3) != 0);
            br = ($urandom_range(0, 3) == 0);
            p4 = $urandom;
            tg = ($urandom_range(0, 1) == 0) ? p4 : $urandom;
            step(st, rd, br, p4, tg);
        end

        // Reset in the middle of a drain discards the pending target
        step(0, 0, 1, 32'h0, 32'h500);
        step(0, 0, 0, 32'h0, 32'h0);
        apply_reset();
        step(0, 1, 0, 32'h0, 32'h0);
        check("post_drain_rst_pc", bus.Pc, RST_PC);
        check("post_drain_rst_cnt", bus.Redirect_cnt, 16'h0);
        step(0, 1, 0, 32'h0, 32'h0);
        check("post_drain_rst_pc2", bus.Pc, RST_PC + 32'd4);
        step(0, 1, 0, 32'h0, 32'h0);

        // Counter saturation: back-to-back redirects while the memory is busy
        apply_reset();
        step(0, 1, 0, 32'h0, 32'h0);
        quiet = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            step(0, 0, 1, 32'h4, 32'h8);
            if (i == 65533) check("cnt_pre_sat", bus.Redirect_cnt, 16'hFFFE);
        end
        quiet = 1'b0;
        check("cnt_sat", bus.Redirect_cnt, 16'hFFFF);
        step(0, 1, 1, 32'h4, 32'hC);
        check("cnt_sat_hold", bus.Redirect_cnt, 16'hFFFF);
        step(0, 1, 0, 32'h0, 32'h0);
        step(0, 1, 0, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
